snake_game_sequencer: RTL and testbench
=======================================

Name: snake_game_sequencer

Overview:
Top-level game controller for the 8x8 snake board. Sequences the game through idle, init, play, pause, win and lose states. Generates the step-request handshake that advances the snake movement/map datapath once per game tick, runs the BCD seconds countdown, and tracks score. Drives the display-select code that chooses between game view, win face and lose face.

Parameters:
TICK_DIV, 4500000, SYS_CLK cycles between snake steps (>=2)
SEC_DIV, 50000000, SYS_CLK cycles per countdown second (>=2)
START_TENS, 9, countdown tens digit loaded at init (0-9)
START_ONES, 0, countdown ones digit loaded at init (0-9)
WIN_SCORE, 8, items eaten to win (1-15)

Ports:
SYS_CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-low
start_btn  in  1  debounced, synchronous level; rising edge starts/restarts
pause_btn  in  1  debounced, synchronous level; rising edge toggles pause
step_ack  in  1  datapath completed requested step (one-cycle pulse)
eat  in  1  head landed on item; valid only with step_ack
collide  in  1  head hit body; valid only with step_ack
step_req  out  1  request one snake move; held until acked
clear_req  out  1  one-cycle pulse: datapath reloads initial snake/item
state  out  3  0 IDLE, 1 INIT, 2 PLAY, 3 PAUSE, 4 WIN, 5 LOSE
secs_tens  out  4  BCD countdown tens
secs_ones  out  4  BCD countdown ones
score  out  4  items eaten
face_sel  out  2  00 game view, 01 win face, 10 lose face
game_over  out  1  high in WIN or LOSE

Behaviour:
- Reset (RST low, async): state IDLE, step_req 0, clear_req 0, score 0, secs = START_TENS/START_ONES, face_sel 00, game_over 0, tick/sec counters 0, pause-pending 0, edge-detect registers 0.
- Edge detect: one register per button; an edge is current high and previous low. Every edge is a single-cycle event.
- IDLE: start edge -> INIT.
- INIT (exactly 1 cycle):
  - clear_req=1.
  - score<=0, secs<=START, counters<=0.
  - Next state PLAY.
- PLAY, tick counter:
  - Increments each cycle while step_req=0.
  - At TICK_DIV-1: counter<=0 and step_req<=1 on the next edge.
  - step_req stays high until step_ack is sampled high, then drops the following cycle.
  - Only one request is outstanding; the tick counter is frozen while step_req=1.
  - step_ack while step_req=0 is ignored, including eat and collide.
- On an accepted ack:
  - collide=1 -> LOSE; this has top priority.
  - Otherwise eat=1 -> score+1. If the new score equals WIN_SCORE -> WIN.
  - Score never exceeds WIN_SCORE.
- Countdown (PLAY only, independent of the step handshake):
  - Sec counter wraps at SEC_DIV-1, then decrements BCD.
  - ones 0 -> ones 9, tens-1; otherwise ones-1.
  - Reaching 00 -> LOSE, unless the same cycle accepts an ack: collide -> LOSE, win -> WIN (win beats timeout).
  - Secs hold at 00, never wrap below 0.
- Pause:
  - Pause edge in PLAY with step_req=0 -> PAUSE next cycle.
  - If step_req=1, set pause-pending; enter PAUSE the cycle after the ack is accepted, unless that ack ends the game (then pending clears).
  - In PAUSE, tick and sec counters, secs and score are frozen.
  - Pause edge in PAUSE -> PLAY; counters resume from their held values.
- Start edge:
  - In WIN/LOSE -> INIT.
  - In PLAY/PAUSE -> INIT (restart), abandoning any outstanding step_req; step_req drops in INIT.
  - Start edge has priority over pause edge in the same cycle.
- Pause edges in IDLE/INIT/WIN/LOSE are ignored.
- WIN/LOSE:
  - step_req=0 and game_over=1; all counters frozen.
  - face_sel = 01 in WIN, 10 in LOSE, 00 otherwise.
- Outputs are registered; state changes are visible one cycle after the causing event.

Test Plan:
1. Bench parameters TICK_DIV=4, SEC_DIV=10, START=0/3, WIN_SCORE=2. Release reset, pulse start -> clear_req high for exactly 1 cycle, state 1 then 2; step_req rises 4 cycles after PLAY entry.
2. Ack with eat twice at 1-cycle latency -> score 1 then 2; state=4, face_sel=01, game_over=1, step_req stays 0.
3. Never ack -> step_req held high and no new request issued; secs 03->02->01->00 every 10 cycles; state=5, face_sel=10.
4. Ack with eat=1 and collide=1 together -> state=5, score unchanged.
5. Pause edge while step_req=1 -> PLAY held until ack, then state=3. Secs frozen for 50 cycles; second pause edge -> PLAY, countdown resumes from the held value.
6. Assert RST low mid-request, and separately press start during PLAY -> reset returns all outputs to reset values immediately; start drops step_req, INIT reloads secs=03, score=0.

Source files
------------

// File: rtl/snake_game_sequencer.sv
// Game controller for the 8x8 snake board: sequences idle/init/play/pause/win/lose,
// issues one datapath step request per tick, runs the BCD countdown and tracks score.
module snake_game_sequencer #(
  parameter int TICK_DIV   = 4500000,
  parameter int SEC_DIV    = 50000000,
  parameter int START_TENS = 9,
  parameter int START_ONES = 0,
  parameter int WIN_SCORE  = 8
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       step_ack,
  input  logic       eat,
  input  logic       collide,
  output logic       step_req,
  output logic       clear_req,
  output logic [2:0] state,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic [3:0] score,
  output logic [1:0] face_sel,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_DIV - 1);
  localparam logic [3:0]    TENS_INIT = 4'(START_TENS);
  localparam logic [3:0]    ONES_INIT = 4'(START_ONES);
  localparam logic [3:0]    WIN_VAL   = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           step_req_q, step_req_d;
  logic           clear_req_q, clear_req_d;
  logic [3:0]     score_q, score_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     ones_q, ones_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [SW-1:0]  sec_q, sec_d;
  logic           pend_q, pend_d;
  logic           start_prev_q, pause_prev_q;
  logic [1:0]     face_q, face_d;
  logic           over_q, over_d;

  logic           start_edge, pause_edge, ack_ok, sec_wrap, timeout, win_hit;
  logic [3:0]     dec_tens, dec_ones, score_inc;

  assign start_edge = start_btn & ~start_prev_q;
  assign pause_edge = pause_btn & ~pause_prev_q;
  assign ack_ok     = step_req_q & step_ack & (state_q == S_PLAY);
  assign sec_wrap   = (sec_q == SEC_LAST);
  assign score_inc  = score_q + 4'd1;
  assign win_hit    = ack_ok & ~collide & eat & (score_inc == WIN_VAL);

  // Saturating BCD decrement: 00 holds rather than wrapping to 99.
  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end
  end

  assign timeout = sec_wrap & (dec_tens == 4'd0) & (dec_ones == 4'd0);

  always_comb begin
    state_d     = state_q;
    step_req_d  = step_req_q;
    clear_req_d = 1'b0;
    score_d     = score_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    tick_d      = tick_q;
    sec_d       = sec_q;
    pend_d      = pend_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_INIT;
      end
      S_INIT: begin
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (start_edge) begin
          state_d = S_INIT;
        end else begin
          if (sec_wrap) begin
            sec_d  = '0;
            tens_d = dec_tens;
            ones_d = dec_ones;
          end else begin
            sec_d = sec_q + 1'b1;
          end

          if (ack_ok) begin
            step_req_d = 1'b0;
            if (collide) begin
              state_d = S_LOSE;
            end else begin
              if (eat) score_d = score_inc;
              if (win_hit)                  state_d = S_WIN;
              else if (timeout)             state_d = S_LOSE;
              else if (pend_q || pause_edge) state_d = S_PAUSE;
            end
          end else if (timeout) begin
            state_d = S_LOSE;
          end else if (step_req_q) begin
            if (pause_edge) pend_d = 1'b1;
          end else if (pause_edge) begin
            // Tick is held on the pause cycle so no request can be raised inside PAUSE.
            state_d = S_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            step_req_d = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (start_edge)      state_d = S_INIT;
        else if (pause_edge) state_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (start_edge) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_PLAY) begin
      step_req_d = 1'b0;
      pend_d     = 1'b0;
    end

    // Reload happens on entry so INIT already shows the fresh game values.
    if (state_d == S_INIT) begin
      clear_req_d = 1'b1;
      score_d     = 4'd0;
      tens_d      = TENS_INIT;
      ones_d      = ONES_INIT;
      tick_d      = '0;
      sec_d       = '0;
    end

    face_d = 2'b00;
    over_d = 1'b0;
    if (state_d == S_WIN) begin
      face_d = 2'b01;
      over_d = 1'b1;
    end else if (state_d == S_LOSE) begin
      face_d = 2'b10;
      over_d = 1'b1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      step_req_q   <= 1'b0;
      clear_req_q  <= 1'b0;
      score_q      <= 4'd0;
      tens_q       <= TENS_INIT;
      ones_q       <= ONES_INIT;
      tick_q       <= '0;
      sec_q        <= '0;
      pend_q       <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      face_q       <= 2'b00;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_req_q   <= step_req_d;
      clear_req_q  <= clear_req_d;
      score_q      <= score_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      tick_q       <= tick_d;
      sec_q        <= sec_d;
      pend_q       <= pend_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
      face_q       <= face_d;
      over_q       <= over_d;
    end
  end

  assign state     = state_q;
  assign step_req  = step_req_q;
  assign clear_req = clear_req_q;
  assign score     = score_q;
  assign secs_tens = tens_q;
  assign secs_ones = ones_q;
  assign face_sel  = face_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer with small dividers (tick 4, second 10, start 03, win 2).
module tb_snake_game_sequencer;

  logic       SYS_CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       step_ack = 1'b0;
  logic       eat = 1'b0;
  logic       collide = 1'b0;
  logic       step_req, clear_req, game_over;
  logic [2:0] state;
  logic [3:0] secs_tens, secs_ones, score;
  logic [1:0] face_sel;

  int checks = 0;
  int errors = 0;
  int n;

  snake_game_sequencer #(
    .TICK_DIV(4), .SEC_DIV(10), .START_TENS(0), .START_ONES(3), .WIN_SCORE(2)
  ) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .start_btn(start_btn), .pause_btn(pause_btn),
    .step_ack(step_ack), .eat(eat), .collide(collide), .step_req(step_req),
    .clear_req(clear_req), .state(state), .secs_tens(secs_tens), .secs_ones(secs_ones),
    .score(score), .face_sel(face_sel), .game_over(game_over)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    while (!step_req && cyc < 20) begin
      step();
      cyc++;
    end
    chk("req_wait", step_req, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_req"}, step_req, 0);
    chk({tag, "_clr"}, clear_req, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_tens"}, secs_tens, 0);
    chk({tag, "_ones"}, secs_ones, 3);
    chk({tag, "_face"}, face_sel, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    step();
    chk("init_state", state, 1);
    chk("init_clr", clear_req, 1);
    chk("init_score", score, 0);
    chk("init_secs", {secs_tens, secs_ones}, 8'h03);
    start_btn = 1'b0;
    step();
    chk("play_state", state, 2);
    chk("play_clr", clear_req, 0);
  endtask

  task automatic ack(input logic e, input logic c);
    step_ack = 1'b1; eat = e; collide = c;
    step();
    step_ack = 1'b0; eat = 1'b0; collide = 1'b0;
  endtask

  initial begin
    // Reset values and pause ignored in IDLE
    repeat (3) @(posedge SYS_CLK);
    #1;
    check_idle_outputs("rst");
    RST = 1'b1;
    step();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    chk("idle_pause_ign", state, 0);
    step();

    // 1: start, INIT for one cycle, request four cycles after PLAY entry
    start_game();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("req_low_early", step_req, 0);
    end
    step();
    chk("req_rise_t4", step_req, 1);

    // 2: two eats at 1-cycle ack latency -> WIN
    ack(1'b1, 1'b0);
    chk("score1", score, 1);
    chk("req_drop", step_req, 0);
    chk("still_play", state, 2);
    wait_req(n);
    chk("req_gap", n, 4);
    ack(1'b1, 1'b0);
    chk("win_state", state, 4);
    chk("win_score", score, 2);
    chk("win_face", face_sel, 1);
    chk("win_over", game_over, 1);
    chk("win_req", step_req, 0);
    repeat (6) step();
    chk("win_hold_req", step_req, 0);
    chk("win_hold_state", state, 4);

    // 3: never ack -> request held, countdown to LOSE
    start_game();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 9)  chk("secs_9", {secs_tens, secs_ones}, 8'h03);
      if (i == 10) chk("secs_10", {secs_tens, secs_ones}, 8'h02);
      if (i == 20) chk("secs_20", {secs_tens, secs_ones}, 8'h01);
      if (i == 25) chk("req_held", step_req, 1);
      if (i == 29) chk("play_29", state, 2);
    end
    chk("to_state", state, 5);
    chk("to_secs", {secs_tens, secs_ones}, 8'h00);
    chk("to_face", face_sel, 2);
    chk("to_over", game_over, 1);
    chk("to_req", step_req, 0);
    repeat (12) step();
    chk("to_secs_hold", {secs_tens, secs_ones}, 8'h00);

    // 4: eat and collide together -> LOSE without scoring
    start_game();
    wait_req(n);
    chk("req_gap4", n, 4);
    ack(1'b1, 1'b1);
    chk("col_state", state, 5);
    chk("col_score", score, 0);
    chk("col_face", face_sel, 2);

    // 5: pause while request outstanding
    start_game();
    wait_req(n);
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    chk("pend_state", state, 2);
    chk("pend_req", step_req, 1);
    repeat (2) step();
    chk("pend_hold", state, 2);
    ack(1'b0, 1'b0);
    chk("pause_state", state, 3);
    chk("pause_req", step_req, 0);
    repeat (50) step();
    chk("pause_secs", {secs_tens, secs_ones}, 8'h03);
    chk("pause_state50", state, 3);
    chk("pause_req50", step_req, 0);
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    chk("resume_state", state, 2);
    step();
    chk("resume_secs1", {secs_tens, secs_ones}, 8'h03);
    step();
    chk("resume_secs2", {secs_tens, secs_ones}, 8'h02);
    wait_req(n);
    chk("resume_req_gap", n, 2);

    // 6: async reset mid-request, then start restart during PLAY
    @(posedge SYS_CLK);
    #3;
    RST = 1'b0;
    #1;
    check_idle_outputs("arst");
    #2;
    RST = 1'b1;
    step();
    start_game();
    ack(1'b1, 1'b1);
    chk("stray_ack_state", state, 2);
    chk("stray_ack_score", score, 0);
    wait_req(n);
    chk("req_gap6", n, 3);
    ack(1'b1, 1'b0);
    chk("score6", score, 1);
    wait_req(n);
    start_btn = 1'b1;
    pause_btn = 1'b1;
    step();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    chk("rs_state", state, 1);
    chk("rs_req", step_req, 0);
    chk("rs_clr", clear_req, 1);
    chk("rs_score", score, 0);
    chk("rs_secs", {secs_tens, secs_ones}, 8'h03);
    step();
    chk("rs_play", state, 2);
    chk("rs_clr_low", clear_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

endmodule
